// File: rtl/apm_stream.sv
// apm_stream: pipelined, flow-controlled approximate pattern matcher over a symbol stream.
// Optional best-score tracking is built only when APM_BEST_TRACK_EN is defined.
module apm_stream #(
  parameter int SYM_W = 2,
  parameter int PAT_LEN = 16,
  parameter int POS_W = 16,
  localparam int CNT_W = $clog2(PAT_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [SYM_W*PAT_LEN-1:0] cfg_pattern,
  input  logic [PAT_LEN-1:0]       cfg_care,
  input  logic [CNT_W-1:0]         cfg_thresh,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SYM_W-1:0]         in_sym,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         out_score,
  output logic                     out_hit,
  output logic [POS_W-1:0]         out_pos,
  output logic [CNT_W-1:0]         best_score,
  output logic [POS_W-1:0]         best_pos,
  output logic                     done
);
  typedef enum logic [2:0] {IDLE, FILL, RUN, DRAIN, DONE} state_t;
  state_t state_q;
  logic [SYM_W*PAT_LEN-1:0] pat_q, win_q, win_d;
  logic [PAT_LEN-1:0] care_q, cmp_d, s1_cmp_q;
  logic [CNT_W-1:0] thr_q, fill_q, pop_d;
  logic [POS_W-1:0] off_q, s1_pos_q;
  logic s1_v_q, stall, acc, full_d, cfg_ok;
  assign stall = out_valid & !out_ready;
  assign in_ready = (state_q == FILL || state_q == RUN) && !stall;
  assign acc = in_valid & in_ready;
  assign full_d = state_q == RUN || fill_q == CNT_W'(PAT_LEN - 1);
  assign cfg_ok = state_q == IDLE || state_q == DONE;
  assign done = state_q == DONE;
  always_comb begin
    win_d = {in_sym, win_q[SYM_W*PAT_LEN-1:SYM_W]};
    pop_d = '0;
    for (int k = 0; k < PAT_LEN; k++) begin
      cmp_d[k] = care_q[k] & (win_d[k*SYM_W +: SYM_W] == pat_q[k*SYM_W +: SYM_W]);
      pop_d = pop_d + CNT_W'(s1_cmp_q[k]);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q <= '0;
      care_q <= '0;
      thr_q <= '0;
      win_q <= '0;
      fill_q <= '0;
      off_q <= '0;
      s1_v_q <= 1'b0;
      s1_cmp_q <= '0;
      s1_pos_q <= '0;
      out_valid <= 1'b0;
      out_score <= '0;
      out_hit <= 1'b0;
      out_pos <= '0;
    end else begin
      if (cfg_we && cfg_ok) begin
        pat_q <= cfg_pattern;
        care_q <= cfg_care;
        thr_q <= cfg_thresh;
      end
      if (start && cfg_ok) begin
        state_q <= FILL;
        fill_q <= '0;
        off_q <= '0;
      end
      if (acc) begin
        win_q <= win_d;
        if (!full_d) fill_q <= fill_q + CNT_W'(1);
        state_q <= in_last ? DRAIN : full_d ? RUN : FILL;
      end
      if (!stall) begin
        s1_v_q <= acc & full_d;
        s1_cmp_q <= cmp_d;
        s1_pos_q <= off_q;
        if (acc && full_d && !(&off_q)) off_q <= off_q + POS_W'(1);
        out_valid <= s1_v_q;
        out_score <= pop_d;
        out_hit <= pop_d >= thr_q;
        out_pos <= s1_pos_q;
      end
      // finish as soon as the last result is leaving, so done follows its handshake by one cycle
      if (state_q == DRAIN && !s1_v_q && !stall) state_q <= DONE;
    end
  end
`ifdef APM_BEST_TRACK_EN
  logic [CNT_W-1:0] best_score_q;
  logic [POS_W-1:0] best_pos_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best_score_q <= '0;
      best_pos_q <= '0;
    end else if (start && cfg_ok) begin
      best_score_q <= '0;
      best_pos_q <= '0;
    end else if (out_valid && out_ready && out_score > best_score_q) begin
      best_score_q <= out_score;
      best_pos_q <= out_pos;
    end
  end
  assign best_score = best_score_q;
  assign best_pos = best_pos_q;
`else
  assign best_score = '0;
  assign best_pos = '0;
`endif
endmodule

// File: tb/tb_apm_stream.sv
// tb_apm_stream: scoreboard bench for apm_stream with PAT_LEN=4, SYM_W=2.
module tb_apm_stream;
  localparam int SYM_W = 2, PAT_LEN = 4, POS_W = 16, CNT_W = 3;
`ifdef APM_BEST_TRACK_EN
  localparam bit BT = 1'b1;
`else
  localparam bit BT = 1'b0;
`endif
  logic clk = 0, reset = 1, cfg_we = 0, start = 0, in_valid = 0, in_last = 0, out_ready = 1;
  logic [SYM_W*PAT_LEN-1:0] cfg_pattern = '0;
  logic [PAT_LEN-1:0] cfg_care = '0;
  logic [CNT_W-1:0] cfg_thresh = '0;
  logic [SYM_W-1:0] in_sym = '0;
  logic in_ready, out_valid, out_hit, done;
  logic [CNT_W-1:0] out_score, best_score;
  logic [POS_W-1:0] out_pos, best_pos;
  int nt = 0, nf = 0, nres = 0;
  int txt[$];
  logic [19:0] q[$];

  apm_stream #(.SYM_W(SYM_W), .PAT_LEN(PAT_LEN), .POS_W(POS_W)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_care(cfg_care),
    .cfg_thresh(cfg_thresh), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_sym(in_sym), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_score(out_score), .out_hit(out_hit), .out_pos(out_pos), .best_score(best_score),
    .best_pos(best_pos), .done(done));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    nt++;
    if (a !== e) begin
      nf++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic exp_res(input int pos, input int score, input bit hit);
    q.push_back({16'(pos), 3'(score), hit});
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      nres++;
      if (q.size() == 0) begin
        nt++;
        nf++;
        $display("FAIL unexpected_result: got pos %0d score %0d, expected none", out_pos, out_score);
      end else chk("result", 32'({out_pos, out_score, out_hit}), 32'(q.pop_front()));
    end
  end

  task automatic setup(input logic [7:0] p, input logic [3:0] c, input logic [2:0] t);
    cfg_pattern = p;
    cfg_care = c;
    cfg_thresh = t;
    cfg_we = 1;
    start = 1;
    @(posedge clk); #1;
    cfg_we = 0;
    start = 0;
  endtask

  task automatic send_text(input bit last);
    for (int i = 0; i < txt.size(); i++) begin
      int n = 0;
      in_valid = 1;
      in_sym = 2'(txt[i]);
      in_last = last && (i == txt.size() - 1);
      while (1) begin
        @(negedge clk);
        if (in_ready) break;
        if (++n > 50) begin
          chk("in_ready_timeout", 0, 1);
          break;
        end
      end
      @(posedge clk); #1;
      in_valid = 0;
      in_last = 0;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("done", 32'(done), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 32'(q.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic bp_ctrl();
    logic [19:0] snap;
    int n = 0;
    while (n < 50) begin
      @(posedge clk); #1;
      if (out_valid) break;
      n++;
    end
    out_ready = 0;
    snap = {out_pos, out_score, out_hit};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_stable", 32'({out_pos, out_score, out_hit}), 32'(snap));
    end
    @(posedge clk); #1;
    out_ready = 1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out", 32'({out_valid, out_score, out_hit, out_pos}), 0);
    chk("rst_best", 32'({best_score, best_pos}), 0);
    chk("rst_done", 32'(done), 0);
    @(posedge clk); #1;
    reset = 0;
    // exact match, pattern [1,2,3,0]
    setup(8'h39, 4'hF, 3'd4);
    exp_res(0, 0, 0); exp_res(1, 4, 1); exp_res(2, 0, 0);
    txt = '{0, 1, 2, 3, 0, 1};
    send_text(1);
    wait_done();
    chk("exact_drained", 32'(q.size()), 0);
    chk("exact_best_score", 32'(best_score), BT ? 4 : 0);
    chk("exact_best_pos", 32'(best_pos), BT ? 1 : 0);
    // all don't-care
    setup(8'h39, 4'h0, 3'd0);
    exp_res(0, 0, 1); exp_res(1, 0, 1); exp_res(2, 0, 1);
    send_text(1);
    wait_done();
    chk("dc_drained", 32'(q.size()), 0);
    // partial care on positions 1 and 2
    setup(8'h39, 4'b0110, 3'd2);
    exp_res(0, 0, 0); exp_res(1, 2, 1); exp_res(2, 0, 0);
    send_text(1);
    wait_done();
    chk("partial_drained", 32'(q.size()), 0);
    chk("partial_best_score", 32'(best_score), BT ? 2 : 0);
    // backpressure
    setup(8'h39, 4'hF, 3'd4);
    exp_res(0, 0, 0); exp_res(1, 4, 1); exp_res(2, 0, 0);
    nres = 0;
    fork
      send_text(1);
      bp_ctrl();
    join
    wait_done();
    chk("bp_count", 32'(nres), 3);
    chk("bp_drained", 32'(q.size()), 0);
    // short text
    setup(8'h39, 4'hF, 3'd4);
    nres = 0;
    txt = '{1, 2, 3};
    send_text(1);
    wait_done();
    chk("short_nres", 32'(nres), 0);
    chk("short_best", 32'({best_score, best_pos}), 0);
    setup(8'h39, 4'hF, 3'd3);
    @(negedge clk);
    chk("restart_in_ready", 32'(in_ready), 1);
    chk("restart_done", 32'(done), 0);
    chk("restart_best", 32'({best_score, best_pos}), 0);
    @(posedge clk); #1;
    // reset mid-RUN after two results
    exp_res(0, 3, 1); exp_res(1, 1, 0);
    txt = '{1, 2, 3, 3, 1};
    send_text(0);
    wait_empty();
    @(negedge clk);
    chk("run_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    reset = 1;
    #1;
    chk("midrst_out", 32'({out_valid, out_score, out_hit, out_pos}), 0);
    chk("midrst_ctl", 32'({in_ready, done, best_score, best_pos}), 0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    // ties keep the earliest offset
    setup(8'h39, 4'hF, 3'd3);
    exp_res(0, 3, 1); exp_res(1, 1, 0); exp_res(2, 0, 0); exp_res(3, 0, 0); exp_res(4, 3, 1);
    txt = '{1, 2, 3, 3, 1, 2, 3, 3};
    send_text(1);
    wait_done();
    chk("tie_drained", 32'(q.size()), 0);
    chk("tie_best_score", 32'(best_score), BT ? 3 : 0);
    chk("tie_best_pos", 32'(best_pos), 0);
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end
endmodule
